// File: rtl/vproc_div_res_pack.sv
// Packs DIV result chunks into full vector register writes.
// Define VPROC_DIV_RES_PACK_SKIP_EMPTY_EN to drop all-zero-mask registers.
module vproc_div_res_pack #(
   parameter int unsigned DIV_OP_W = 64,
   parameter int unsigned VREG_W   = 128,
   parameter int unsigned VADDR_W  = 5
) (
   input  logic                  clk_i,
   input  logic                  async_rst_ni,
   input  logic                  sync_rst_ni,
   input  logic                  pipe_in_valid_i,
   output logic                  pipe_in_ready_o,
   input  logic [VADDR_W-1:0]    pipe_in_vaddr_i,
   input  logic                  pipe_in_last_i,
   input  logic [DIV_OP_W-1:0]   pipe_in_res_i,
   input  logic [DIV_OP_W/8-1:0] pipe_in_mask_i,
   output logic                  vreg_wr_valid_o,
   input  logic                  vreg_wr_ready_i,
   output logic [VADDR_W-1:0]    vreg_wr_addr_o,
   output logic [VREG_W-1:0]     vreg_wr_data_o,
   output logic [VREG_W/8-1:0]   vreg_wr_be_o,
   output logic                  busy_o
);

   localparam int unsigned CHUNKS = VREG_W / DIV_OP_W;
   localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int unsigned MASK_W = DIV_OP_W / 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;

   logic [0:0]          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [VADDR_W-1:0]  addr_q;
   logic [VREG_W-1:0]   data_q;
   logic [VREG_W/8-1:0] be_q;

   logic                accept;
   logic                hs;
   logic                fin;
   logic                drop;
   logic [VREG_W-1:0]   data_nxt;
   logic [VREG_W/8-1:0] be_nxt;

   assign pipe_in_ready_o = (state_q == FILL) | vreg_wr_ready_i;
   assign accept          = pipe_in_valid_i & pipe_in_ready_o;
   assign hs              = (state_q == WRITE) & vreg_wr_ready_i;
   assign fin             = pipe_in_last_i | (cnt_q == CNT_LAST);

   // A chunk accepted on the handshake cycle starts from a cleared be
   always_comb begin
      data_nxt = data_q;
      be_nxt   = hs ? '0 : be_q;
      for (int i = 0; i < CHUNKS; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            data_nxt[i*DIV_OP_W +: DIV_OP_W] = pipe_in_res_i;
            be_nxt[i*MASK_W +: MASK_W]       = pipe_in_mask_i;
         end
      end
   end

`ifdef VPROC_DIV_RES_PACK_SKIP_EMPTY_EN
   assign drop = (be_nxt == '0);
`else
   assign drop = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         state_q <= FILL;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
      end else if (!sync_rst_ni) begin
         state_q <= FILL;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
      end else if (accept) begin
         data_q <= data_nxt;
         be_q   <= be_nxt;
         if (cnt_q == '0) begin
            addr_q <= pipe_in_vaddr_i;
         end
         if (fin) begin
            cnt_q   <= '0;
            state_q <= drop ? FILL : WRITE;
         end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= FILL;
         end
      end else if (hs) begin
         be_q    <= '0;
         state_q <= FILL;
      end
   end

   assign vreg_wr_valid_o = (state_q == WRITE);
   assign vreg_wr_addr_o  = addr_q;
   assign vreg_wr_data_o  = data_q;
   assign vreg_wr_be_o    = be_q;
   assign busy_o          = (state_q == WRITE) | (cnt_q != '0);

endmodule
